// File: rtl/alu_issue_stage.sv
// Operand-fetch / issue / writeback stage in front of the ALU32 datapath.
// One register-register op in flight at a time: IDLE -> READ -> EXEC -> WB -> IDLE.
module alu_issue_stage #(
  parameter int N    = 32,
  parameter int NREG = 16,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_func,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [AW-1:0] in_rd,
  output logic [3:0]    alu_func,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  input  logic [N-1:0]  alu_res,
  output logic          out_valid,
  output logic [AW-1:0] out_rd,
  output logic [N-1:0]  out_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [N-1:0]  dbg_data,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]    func_q;
  logic [AW-1:0] rs_q;
  logic [AW-1:0] rt_q;
  logic [AW-1:0] rd_q;
  logic [N-1:0]  res_q;
  logic [N-1:0]  rf [NREG];
  logic [N-1:0]  rd_a;
  logic [N-1:0]  rd_b;
  logic          accept;

  // Handshake: an op transfers on a rising edge where in_valid && in_ready.
  // in_ready is high only in IDLE; in_valid seen in any other state is ignored
  // and nothing is held for it. out_valid has no ready: it is a one-cycle pulse.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_READ;
      end
      S_READ: state_next = S_EXEC;
      S_EXEC: state_next = S_WB;
      S_WB: begin
        out_valid  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // R0 reads as zero regardless of bank contents.
  assign rd_a     = (rs_q == '0) ? '0 : rf[rs_q];
  assign rd_b     = (rt_q == '0) ? '0 : rf[rt_q];
  assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];

  assign out_rd    = rd_q;
  assign out_data  = res_q;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      func_q   <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      res_q    <= '0;
      alu_func <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        func_q <= in_func;
        rs_q   <= in_rs;
        rt_q   <= in_rt;
        rd_q   <= in_rd;
      end
      // ALU drive registers keep their last values while idle.
      if (state == S_READ) begin
        alu_a    <= rd_a;
        alu_b    <= rd_b;
        alu_func <= func_q;
      end
      if (state == S_EXEC) res_q <= alu_res;
      if (state == S_WB && rd_q != '0) rf[rd_q] <= res_q;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a latency/register-bank model checks every
// cycle, and literal expectations pin the model at each scenario.
module tb_alu_issue_stage;
  localparam int N = 32;
  localparam int NREG = 16;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_func;
  logic [AW-1:0] in_rs, in_rt, in_rd;
  logic [3:0]    alu_func;
  logic [N-1:0]  alu_a, alu_b, alu_res;
  logic          out_valid;
  logic [AW-1:0] out_rd;
  logic [N-1:0]  out_data;
  logic [AW-1:0] dbg_addr;
  logic [N-1:0]  dbg_data;
  logic [1:0]    dbg_state;

  logic          force_en;
  logic [N-1:0]  force_val;

  int n_vec = 0;
  int n_err = 0;

  alu_issue_stage #(.N(N), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .out_valid(out_valid), .out_rd(out_rd), .out_data(out_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  // ALU stub: XOR unless a forced result is requested.
  assign alu_res = force_en ? force_val : (alu_a ^ alu_b);

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model + scoreboard ----------------
  logic [N-1:0]  m_rf [NREG];
  int            m_busy;
  logic [AW-1:0] m_rd;
  logic [N-1:0]  m_res, m_a, m_b;
  logic [3:0]    m_func;
  logic [3:0]    m_alu_func;
  logic [N-1:0]  m_alu_a, m_alu_b;
  logic [N-1:0]  exp_q[$];
  logic [AW-1:0] exp_rd_q[$];
  int            cyc = 0;
  int            prev_acc = 0, last_acc = 0, last_wb = 0;
  logic [AW-1:0] last_wb_rd;
  logic [N-1:0]  last_wb_data;
  logic [3:0]    exec_func;

  initial begin
    logic [N-1:0] a, b, exp_dbg;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        for (int i = 0; i < NREG; i++) m_rf[i] = '0;
        m_busy = 0;
        m_alu_func = '0;
        m_alu_a = '0;
        m_alu_b = '0;
        exp_q.delete();
        exp_rd_q.delete();
      end else if (m_busy == 0) begin
        if (in_valid) begin
          a = (in_rs == 0) ? '0 : m_rf[in_rs];
          b = (in_rt == 0) ? '0 : m_rf[in_rt];
          m_a = a;
          m_b = b;
          m_func = in_func;
          m_rd = in_rd;
          m_res = force_en ? force_val : (a ^ b);
          m_busy = 3;
          exp_q.push_back(m_res);
          exp_rd_q.push_back(in_rd);
          prev_acc = last_acc;
          last_acc = cyc;
        end
      end else begin
        m_busy--;
        if (m_busy == 2) begin
          m_alu_func = m_func;
          m_alu_a = m_a;
          m_alu_b = m_b;
          exec_func = alu_func;
        end
        if (m_busy == 0 && m_rd != 0) m_rf[m_rd] = m_res;
      end

      check("in_ready", {31'd0, in_ready}, {31'd0, m_busy == 0});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_busy == 1});
      check("alu_func", {28'd0, alu_func}, {28'd0, m_alu_func});
      check("alu_a", alu_a, m_alu_a);
      check("alu_b", alu_b, m_alu_b);
      exp_dbg = (dbg_addr == 0) ? '0 : m_rf[dbg_addr];
      check("dbg_data", dbg_data, exp_dbg);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
          check("out_rd", {28'd0, out_rd}, {28'd0, exp_rd_q.pop_front()});
        end
        last_wb = cyc;
        last_wb_rd = out_rd;
        last_wb_data = out_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] f, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                      input logic [AW-1:0] rd, input bit hold);
    int n;
    @(negedge clk);
    in_func = f;
    in_rs = rs;
    in_rt = rt;
    in_rd = rd;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Called at a negedge; counts cycles with in_ready low.
  task automatic wait_idle(output int n);
    n = 0;
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic peek(input string name, input logic [AW-1:0] addr, input logic [N-1:0] exp);
    @(negedge clk);
    dbg_addr = addr;
    #1;
    check(name, dbg_data, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lo;
    rst = 1'b1;
    in_valid = 1'b0;
    in_func = '0;
    in_rs = '0;
    in_rt = '0;
    in_rd = '0;
    dbg_addr = '0;
    force_en = 1'b0;
    force_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: reset state
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_rd", {28'd0, out_rd}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    for (int i = 0; i < NREG; i++) peek("rst_rf", i[AW-1:0], 32'd0);

    // 2: preload R3 through R0 operands with forced result
    force_en = 1'b1;
    force_val = 32'h0000_00FF;
    send(4'h0, 4'd0, 4'd0, 4'd3, 1'b0);
    wait_idle(lo);
    force_en = 1'b0;
    check("wb_latency", last_wb - last_acc, 32'd2);
    check("preload_rd", {28'd0, last_wb_rd}, 32'd3);
    peek("preload_r3", 4'd3, 32'h0000_00FF);

    force_en = 1'b1;
    force_val = 32'h0000_0F0F;
    send(4'h0, 4'd0, 4'd0, 4'd4, 1'b0);
    wait_idle(lo);
    force_en = 1'b0;
    peek("preload_r4", 4'd4, 32'h0000_0F0F);

    // 3: XOR op, func passthrough and busy window
    send(4'b0101, 4'd3, 4'd4, 4'd5, 1'b0);
    wait_idle(lo);
    check("busy_cycles", lo, 32'd3);
    check("exec_func", {28'd0, exec_func}, 32'd5);
    peek("xor_r5", 4'd5, 32'h0000_0FF0);

    // 4: write to R0 is discarded but still reported
    send(4'b0101, 4'd3, 4'd4, 4'd0, 1'b0);
    wait_idle(lo);
    check("r0_wb_data", last_wb_data, 32'h0000_0FF0);
    check("r0_wb_rd", {28'd0, last_wb_rd}, 32'd0);
    peek("r0_read", 4'd0, 32'd0);

    // 5: back-to-back dependent ops with in_valid held high
    send(4'h1, 4'd5, 4'd3, 4'd5, 1'b1);
    send(4'h2, 4'd5, 4'd5, 4'd6, 1'b0);
    check("raw_accept_gap", prev_acc == 0 ? 32'hFFFF_FFFF : last_acc - prev_acc, 32'd4);
    wait_idle(lo);
    peek("raw_r5", 4'd5, 32'h0000_0F0F);
    peek("raw_r6", 4'd6, 32'd0);

    // 6: reset while the op is in EXEC
    send(4'h3, 4'd3, 4'd4, 4'd7, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    repeat (4) @(negedge clk);
    peek("rst_mid_r7", 4'd7, 32'd0);
    for (int i = 0; i < NREG; i++) peek("rst_mid_rf", i[AW-1:0], 32'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
